player_path_controller: RTL and testbench

- Parametrised successor to the single-step player mover in the board-game UI renderer.
- Accepts multi-tile move commands through a valid/ready handshake, forward or backward, with destination clamped to the board.
- Animates one horizontal slide per tile, then one landing jump, paced by a per-frame tick.
- Drives the sprite position consumed by the VGA draw path.

---
 rtl/player_path_controller.sv | 144 ++++++++++++++
 tb/tb_player_path_controller.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_path_controller.sv
// Multi-tile sprite path controller: accepts clamped forward/backward moves and
// animates one slide per tile plus a landing jump, advancing only on frame_tick.
module player_path_controller #(
    parameter int NUM_TILES   = 10,
    parameter int TILE_SIZE   = 48,
    parameter int X_OFFSET    = 16,
    parameter int BASE_Y      = 124,
    parameter int MOVE_FRAMES = 24,
    parameter int JUMP_FRAMES = 16,
    parameter int JUMP_HEIGHT = 30,
    parameter int STEP_W      = 3,
    localparam int TILE_W     = $clog2(NUM_TILES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_tick,
    input  logic              move_valid,
    input  logic [STEP_W-1:0] move_steps,
    input  logic              move_dir,
    output logic              move_ready,
    output logic [9:0]        player_x,
    output logic [9:0]        player_y,
    output logic [TILE_W-1:0] current_tile,
    output logic              is_moving,
    output logic              move_done,
    output logic              at_goal
);

    localparam int CNT_MAX = (MOVE_FRAMES > JUMP_FRAMES) ? MOVE_FRAMES : JUMP_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int HALF    = JUMP_FRAMES / 2;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MOVING  = 2'd1;
    localparam logic [1:0] JUMPING = 2'd2;

    logic [1:0]        state;
    logic [TILE_W-1:0] tile;
    logic [CNT_W-1:0]  counter;
    logic [STEP_W-1:0] remaining;
    logic              dir;
    logic [9:0]        start_x;
    logic              done;

    logic [31:0]       room;
    logic [STEP_W-1:0] eff;
    logic [TILE_W-1:0] next_tile;
    logic [9:0]        slide;
    logic [9:0]        lift;

    function automatic logic [9:0] tile_x(input logic [TILE_W-1:0] t);
        return 10'(32'(t) * TILE_SIZE + X_OFFSET);
    endfunction

    // Requested step count is clamped to the tiles left in the chosen direction.
    always_comb begin
        room      = move_dir ? 32'(tile) : (32'(NUM_TILES - 1) - 32'(tile));
        eff       = (32'(move_steps) < room) ? move_steps : STEP_W'(room);
        next_tile = dir ? (tile - TILE_W'(1)) : (tile + TILE_W'(1));
    end

    // Handshake: a command transfers on any clk edge where move_valid && move_ready;
    // move_ready is high only in IDLE, so commands offered while busy are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tile      <= '0;
            counter   <= '0;
            remaining <= '0;
            dir       <= 1'b0;
            start_x   <= 10'(X_OFFSET);
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (move_valid) begin
                        dir <= move_dir;
                        if (eff == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= MOVING;
                            counter   <= '0;
                            remaining <= eff;
                            start_x   <= tile_x(tile);
                        end
                    end
                end
                MOVING: begin
                    if (frame_tick) begin
                        if (counter < CNT_W'(MOVE_FRAMES - 1)) begin
                            counter <= counter + CNT_W'(1);
                        end else begin
                            // Commit the tile at the end of the slide so x stays monotonic.
                            tile      <= next_tile;
                            start_x   <= tile_x(next_tile);
                            counter   <= '0;
                            remaining <= remaining - STEP_W'(1);
                            if (remaining == STEP_W'(1))
                                state <= JUMPING;
                        end
                    end
                end
                JUMPING: begin
                    if (frame_tick) begin
                        if (counter == CNT_W'(JUMP_FRAMES - 1)) begin
                            state   <= IDLE;
                            counter <= '0;
                            done    <= 1'b1;
                        end else begin
                            counter <= counter + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        slide = 10'((TILE_SIZE * 32'(counter)) / MOVE_FRAMES);
        if (32'(counter) < HALF)
            lift = 10'((32'(counter) * JUMP_HEIGHT) / HALF);
        else
            lift = 10'(((JUMP_FRAMES - 32'(counter)) * JUMP_HEIGHT) / HALF);

        if (state == MOVING)
            player_x = dir ? (start_x - slide) : (start_x + slide);
        else
            player_x = tile_x(tile);

        if (state == JUMPING)
            player_y = 10'(BASE_Y) - lift;
        else
            player_y = 10'(BASE_Y);
    end

    assign move_ready   = (state == IDLE);
    assign is_moving    = (state != IDLE);
    assign current_tile = tile;
    assign move_done    = done;
    assign at_goal      = (tile == TILE_W'(NUM_TILES - 1));

endmodule

// File: tb/tb_player_path_controller.sv
// Bench for player_path_controller: tick-count based reference model checked every
// cycle, directed scenarios with literal positions, then randomized commands.
module tb_player_path_controller;

    localparam int NT = 10;
    localparam int TS = 48;
    localparam int XO = 16;
    localparam int BY = 124;
    localparam int MF = 24;
    localparam int JF = 16;
    localparam int JH = 30;
    localparam int SW = 3;
    localparam int TW = $clog2(NT);
    localparam int H  = JF / 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          frame_tick;
    logic          move_valid;
    logic [SW-1:0] move_steps;
    logic          move_dir;
    logic          move_ready;
    logic [9:0]    player_x;
    logic [9:0]    player_y;
    logic [TW-1:0] current_tile;
    logic          is_moving;
    logic          move_done;
    logic          at_goal;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    player_path_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .move_valid   (move_valid),
        .move_steps   (move_steps),
        .move_dir     (move_dir),
        .move_ready   (move_ready),
        .player_x     (player_x),
        .player_y     (player_y),
        .current_tile (current_tile),
        .is_moving    (is_moving),
        .move_done    (move_done),
        .at_goal      (at_goal)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a command is described by start tile, direction, clamped
    // length and the number of frame ticks elapsed since acceptance.
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_dir = 1'b0;
    int m_tile = 0;
    int m_start = 0;
    int m_eff = 0;
    int m_k = 0;
    int m_room;
    int m_req;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_tile = 0;
            m_k    = 0;
            m_eff  = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (move_valid) begin
                    m_room = move_dir ? m_tile : (NT - 1 - m_tile);
                    m_req  = int'(move_steps);
                    m_eff  = (m_req < m_room) ? m_req : m_room;
                    if (m_eff == 0) begin
                        m_done = 1'b1;
                    end else begin
                        m_busy  = 1'b1;
                        m_start = m_tile;
                        m_dir   = move_dir;
                        m_k     = 0;
                    end
                end
            end else if (frame_tick) begin
                m_k++;
                if (m_k == m_eff * MF + JF) begin
                    m_busy = 1'b0;
                    m_tile = m_dir ? (m_start - m_eff) : (m_start + m_eff);
                    m_done = 1'b1;
                end
            end
        end
    end

    function automatic int tile_px(input int t);
        return t * TS + XO;
    endfunction

    // scoreboard: compare every cycle on the falling edge
    int e_tile, e_x, e_y, e_j, e_c;
    always @(negedge clk) begin
        if (cmp_en) begin
            if (!m_busy) begin
                e_tile = m_tile;
                e_x    = tile_px(e_tile);
                e_y    = BY;
            end else if (m_k < m_eff * MF) begin
                e_tile = m_dir ? (m_start - m_k / MF) : (m_start + m_k / MF);
                e_c    = m_k % MF;
                e_x    = m_dir ? (tile_px(e_tile) - TS * e_c / MF) : (tile_px(e_tile) + TS * e_c / MF);
                e_y    = BY;
            end else begin
                e_j    = m_k - m_eff * MF;
                e_tile = m_dir ? (m_start - m_eff) : (m_start + m_eff);
                e_x    = tile_px(e_tile);
                e_y    = BY - ((e_j < H) ? (e_j * JH / H) : ((JF - e_j) * JH / H));
            end
            check("cyc_player_x", player_x, e_x);
            check("cyc_player_y", player_y, e_y);
            check("cyc_tile", current_tile, e_tile);
            check("cyc_ready", move_ready, !m_busy);
            check("cyc_moving", is_moving, m_busy);
            check("cyc_done", move_done, m_done);
            check("cyc_goal", at_goal, e_tile == NT - 1);
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n, input int gap);
        repeat (n) begin
            frame_tick = 1'b0;
            repeat (gap - 1) step();
            frame_tick = 1'b1;
            step();
        end
        frame_tick = 1'b0;
    endtask

    task automatic issue(input int s, input bit d);
        move_valid = 1'b1;
        move_steps = s[SW-1:0];
        move_dir   = d;
        step();
        move_valid = 1'b0;
    endtask

    int gap;
    int budget;

    initial begin
        frame_tick = 1'b0;
        move_valid = 1'b0;
        move_steps = '0;
        move_dir   = 1'b0;
        #2;
        rst_n  = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        check("rst_x", player_x, 16);
        check("rst_y", player_y, 124);
        check("rst_tile", current_tile, 0);
        check("rst_ready", move_ready, 1);
        check("rst_goal", at_goal, 0);
        check("rst_done", move_done, 0);
        run_ticks(5, 1);
        check("idle_ticks_x", player_x, 16);
        check("idle_ticks_tile", current_tile, 0);

        // tile 0, three steps forward, tick every cycle
        issue(3, 1'b0);
        check("s1_moving", is_moving, 1);
        check("s1_ready", move_ready, 0);
        run_ticks(12, 1);
        check("s1_x_mid", player_x, 40);
        run_ticks(12, 1);
        check("s1_tile1", current_tile, 1);
        run_ticks(24, 1);
        check("s1_tile2", current_tile, 2);
        run_ticks(24, 1);
        check("s1_tile3", current_tile, 3);
        run_ticks(8, 1);
        check("s1_apex_y", player_y, 94);
        run_ticks(8, 1);
        check("s1_done", move_done, 1);
        check("s1_final_x", player_x, 160);
        check("s1_idle", is_moving, 0);
        step();
        check("s1_done_pulse", move_done, 0);

        // clamping at the top end of the board
        issue(5, 1'b0);
        run_ticks(5 * MF + JF, 1);
        check("s2_tile8", current_tile, 8);
        issue(5, 1'b0);
        run_ticks(MF + JF, 1);
        check("s2_tile9", current_tile, 9);
        check("s2_goal", at_goal, 1);
        check("s2_x", player_x, 448);
        issue(4, 1'b0);
        check("s2_zero_done", move_done, 1);
        check("s2_zero_idle", is_moving, 0);
        step();
        check("s2_zero_pulse", move_done, 0);
        check("s2_zero_tile", current_tile, 9);

        // backward with clamping at tile 0
        issue(7, 1'b1);
        run_ticks(7 * MF + JF, 1);
        check("s3_tile2", current_tile, 2);
        issue(7, 1'b1);
        run_ticks(12, 1);
        check("s3_x_mid", player_x, 88);
        run_ticks(12 + MF + JF, 1);
        check("s3_tile0", current_tile, 0);
        check("s3_x", player_x, 16);

        // ticks every 4th cycle, command offered while busy
        issue(3, 1'b0);
        run_ticks(12, 4);
        check("s4_x_mid", player_x, 40);
        move_valid = 1'b1;
        move_steps = 3'd2;
        move_dir   = 1'b1;
        step();
        move_valid = 1'b0;
        check("s4_ready_busy", move_ready, 0);
        check("s4_x_hold", player_x, 40);
        run_ticks(12, 4);
        check("s4_tile1", current_tile, 1);
        run_ticks(48, 4);
        check("s4_tile3", current_tile, 3);
        run_ticks(8, 4);
        check("s4_apex_y", player_y, 94);
        run_ticks(8, 4);
        check("s4_done", move_done, 1);
        check("s4_x", player_x, 160);

        // asynchronous reset during the jump
        issue(2, 1'b0);
        run_ticks(2 * MF + 5, 1);
        check("s5_jump_y", player_y, 106);
        rst_n = 1'b0;
        #1;
        check("s5_rst_x", player_x, 16);
        check("s5_rst_y", player_y, 124);
        check("s5_rst_tile", current_tile, 0);
        check("s5_rst_ready", move_ready, 1);
        check("s5_rst_done", move_done, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("s5_post_done", move_done, 0);
        issue(2, 1'b0);
        run_ticks(2 * MF + JF, 1);
        check("s5_new_tile", current_tile, 2);
        check("s5_new_done", move_done, 1);
        check("s5_new_x", player_x, 112);

        // randomized commands with noise
        for (int n = 0; n < 30; n++) begin
            gap = $urandom_range(1, 4);
            repeat ($urandom_range(0, 3)) begin
                frame_tick = 1'($urandom_range(0, 1));
                step();
            end
            frame_tick = 1'b0;
            issue($urandom_range(0, 7), 1'($urandom_range(0, 1)));
            budget = 2000;
            while (m_busy && budget > 0) begin
                frame_tick = ($urandom_range(0, gap - 1) == 0);
                move_valid = ($urandom_range(0, 15) == 0);
                move_steps = SW'($urandom_range(0, 7));
                move_dir   = 1'($urandom_range(0, 1));
                step();
                budget--;
            end
            frame_tick = 1'b0;
            move_valid = 1'b0;
            if (budget == 0) begin
                failures++;
                $display("FAIL rand_timeout actual=busy required=idle cmd=%0d", n);
            end
        end
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
